// File: rtl/axis_dp_pkg.sv
// Shared definitions for the AXI-Stream datapath stages (splitter, padding, counters).
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package axis_dp_pkg;

    localparam int IN_W  = 64;
    localparam int OUT_W = 32;
    localparam int CNT_W = 32;

    // EMPTY: nothing held; FIRST: first half on the output; SECOND: second half on the output.
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } fsm_state_e;

    // Pick one 32-bit half of a 64-bit frame.
    function automatic logic [OUT_W-1:0] split_half(input logic [IN_W-1:0] frame,
                                                    input logic            take_high);
        return take_high ? frame[IN_W-1:OUT_W] : frame[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/axis_pkt_counter.sv
// Counts accepted frames and publishes the frame count of each completed packet.
// Latency: pkt_frames_o/pkt_done_o update one cycle after the handshake carrying tlast.
// Backpressure: none; only qualified handshakes (hsk_i) advance the count.
//
// Ports: clk_i/rst_i (sync active-high reset), hsk_i (input frame accepted),
//        last_i (that frame ends the packet), pkt_frames_o (frames in last packet),
//        pkt_done_o (one-cycle pulse when pkt_frames_o updates).
module axis_pkt_counter
    import axis_dp_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hsk_i,
    input  logic             last_i,
    output logic [CNT_W-1:0] pkt_frames_o,
    output logic             pkt_done_o
);

    logic [CNT_W-1:0] frame_cnt_q,  frame_cnt_d;
    logic [CNT_W-1:0] pkt_frames_q, pkt_frames_d;
    logic             pkt_done_q,   pkt_done_d;

    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        pkt_frames_d = pkt_frames_q;
        pkt_done_d   = 1'b0;
        if (hsk_i) begin
            if (last_i) begin
                // The closing frame itself counts, so a one-frame packet reports 1.
                pkt_frames_d = frame_cnt_q + CNT_W'(1);
                frame_cnt_d  = '0;
                pkt_done_d   = 1'b1;
            end else begin
                // Wraps naturally modulo 2^CNT_W.
                frame_cnt_d  = frame_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_cnt_q  <= '0;
            pkt_frames_q <= '0;
            pkt_done_q   <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            pkt_frames_q <= pkt_frames_d;
            pkt_done_q   <= pkt_done_d;
        end
    end

    assign pkt_frames_o = pkt_frames_q;
    assign pkt_done_o   = pkt_done_q;

endmodule

// File: rtl/axis_frame_split.sv
// Splits each 64-bit input frame into two 32-bit output words, order set by HIGH_FIRST.
// Latency: first half valid one cycle after the input handshake; one word per cycle sustained.
// Backpressure: input ready only when empty or when the second half is leaving this cycle.
//
// Ports: s_axis_aclk (clock), s_axis_areset (sync active-high reset),
//        s_axis_* (64-bit frame input), m_axis_* (32-bit word output),
//        m_axis_hsked (output handshake), pkt_frames/pkt_done (per-packet frame count).
module axis_frame_split
    import axis_dp_pkg::*;
#(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic             s_axis_aclk,
    input  logic             s_axis_areset,
    output logic             s_axis_tready,
    input  logic [IN_W-1:0]  s_axis_tdata,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [OUT_W-1:0] m_axis_tdata,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    output logic             m_axis_hsked,
    output logic [CNT_W-1:0] pkt_frames,
    output logic             pkt_done
);

    fsm_state_e       state_q,  state_d;
    logic [IN_W-1:0]  data_q,   data_d;
    logic             last_q,   last_d;
    logic [OUT_W-1:0] tdata_q,  tdata_d;
    logic             tlast_q,  tlast_d;
    logic             tvalid_q, tvalid_d;
    logic             tready_c;
    logic             s_hsk;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        last_d   = last_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        tready_c = 1'b0;

        unique case (state_q)
            EMPTY: begin
                tready_c = 1'b1;
                if (s_axis_tvalid) begin
                    state_d  = FIRST;
                    data_d   = s_axis_tdata;
                    last_d   = s_axis_tlast;
                    tdata_d  = split_half(s_axis_tdata, HIGH_FIRST);
                    tlast_d  = 1'b0;
                    tvalid_d = 1'b1;
                end
            end
            FIRST: begin
                if (m_axis_tready) begin
                    state_d = SECOND;
                    tdata_d = split_half(data_q, !HIGH_FIRST);
                    tlast_d = last_q;
                end
            end
            SECOND: begin
                // The output register frees up this cycle exactly when the consumer
                // takes the second half, so a new frame can be loaded behind it.
                tready_c = m_axis_tready;
                if (m_axis_tready) begin
                    if (s_axis_tvalid) begin
                        state_d  = FIRST;
                        data_d   = s_axis_tdata;
                        last_d   = s_axis_tlast;
                        tdata_d  = split_half(s_axis_tdata, HIGH_FIRST);
                        tlast_d  = 1'b0;
                        tvalid_d = 1'b1;
                    end else begin
                        state_d  = EMPTY;
                        tlast_d  = 1'b0;
                        tvalid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d  = EMPTY;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state_q  <= EMPTY;
            data_q   <= '0;
            last_q   <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            last_q   <= last_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    // Hold off the upstream stage for the whole reset window.
    assign s_axis_tready = tready_c & ~s_axis_areset;
    assign s_hsk         = s_axis_tvalid & s_axis_tready;

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_hsked  = tvalid_q & m_axis_tready;

    axis_pkt_counter u_pkt_counter (
        .clk_i        (s_axis_aclk),
        .rst_i        (s_axis_areset),
        .hsk_i        (s_hsk),
        .last_i       (s_axis_tlast),
        .pkt_frames_o (pkt_frames),
        .pkt_done_o   (pkt_done)
    );

endmodule

// File: tb/tb_axis_frame_split.sv
module tb_axis_frame_split;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        areset;
    logic        s_tvalid;
    logic        s_tlast;
    logic [63:0] s_tdata;
    logic        m_tready;

    logic        s_tready_a, m_tlast_a, m_tvalid_a, m_hsked_a, pkt_done_a;
    logic [31:0] m_tdata_a, pkt_frames_a;
    logic        s_tready_b, m_tlast_b, m_tvalid_b, m_hsked_b, pkt_done_b;
    logic [31:0] m_tdata_b, pkt_frames_b;

    axis_frame_split #(.HIGH_FIRST(1'b1)) dut_a (
        .s_axis_aclk   (clk),
        .s_axis_areset (areset),
        .s_axis_tready (s_tready_a),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata_a),
        .m_axis_tlast  (m_tlast_a),
        .m_axis_tvalid (m_tvalid_a),
        .m_axis_hsked  (m_hsked_a),
        .pkt_frames    (pkt_frames_a),
        .pkt_done      (pkt_done_a)
    );

    axis_frame_split #(.HIGH_FIRST(1'b0)) dut_b (
        .s_axis_aclk   (clk),
        .s_axis_areset (areset),
        .s_axis_tready (s_tready_b),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata_b),
        .m_axis_tlast  (m_tlast_b),
        .m_axis_tvalid (m_tvalid_b),
        .m_axis_hsked  (m_hsked_b),
        .pkt_frames    (pkt_frames_b),
        .pkt_done      (pkt_done_b)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } word_t;

    word_t       got_q[$];
    word_t       got_b[$];
    word_t       exp_w[$];
    int          got_cyc[$];
    logic [31:0] done_q[$];
    logic [31:0] exp_done[$];
    logic [63:0] frm_d[$];
    bit          frm_l[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int stall_err = 0;
    int hsk_err = 0;
    int first_hs_cyc = 0;
    bit          stall_prev = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive observer: logs output words and packet reports, watches stall stability.
    always @(negedge clk) begin
        if (!areset) begin
            if (m_tvalid_a && m_tready) begin
                got_q.push_back('{d: m_tdata_a, l: m_tlast_a});
                got_cyc.push_back(cyc);
            end
            if (m_tvalid_b && m_tready)
                got_b.push_back('{d: m_tdata_b, l: m_tlast_b});
            if (pkt_done_a)
                done_q.push_back(pkt_frames_a);
            if (stall_prev && (!m_tvalid_a || m_tdata_a !== prev_d || m_tlast_a !== prev_l))
                stall_err <= stall_err + 1;
            if (m_hsked_a !== (m_tvalid_a & m_tready))
                hsk_err <= hsk_err + 1;
        end
        stall_prev <= m_tvalid_a && !m_tready && !areset;
        prev_d     <= m_tdata_a;
        prev_l     <= m_tlast_a;
    end

    task automatic clear_logs;
        got_q.delete();
        got_b.delete();
        got_cyc.delete();
        done_q.delete();
        frm_d.delete();
        frm_l.delete();
    endtask

    // Reference: each frame becomes two words in HIGH_FIRST order, tlast on the
    // second word of a closing frame; packet sizes are frames between tlasts.
    task automatic build_exp(input bit hf);
        int n;
        logic [31:0] hi, lo;
        exp_w.delete();
        exp_done.delete();
        n = 0;
        foreach (frm_d[i]) begin
            hi = frm_d[i][63:32];
            lo = frm_d[i][31:0];
            exp_w.push_back('{d: (hf ? hi : lo), l: 1'b0});
            exp_w.push_back('{d: (hf ? lo : hi), l: frm_l[i]});
            n++;
            if (frm_l[i]) begin
                exp_done.push_back(32'(n));
                n = 0;
            end
        end
    endtask

    task automatic drive(input bit rnd);
        int i;
        int n;
        i = 0;
        n = 0;
        while (i < frm_d.size()) begin
            s_tvalid = 1'b1;
            s_tdata  = frm_d[i];
            s_tlast  = frm_l[i];
            m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (s_tready_a) begin
                if (i == 0) first_hs_cyc = cyc;
                i++;
            end
            @(posedge clk); #1;
            n++;
            if (n > 5000) begin
                tests++; fails++;
                $display("FAIL drive_timeout: accepted %0d frames, required %0d", i, frm_d.size());
                break;
            end
        end
        // Junk on the bus while not valid must be ignored.
        s_tvalid = 1'b0;
        s_tdata  = {$urandom, $urandom};
        s_tlast  = 1'($urandom_range(0, 1));
        n = 0;
        while (got_q.size() < exp_w.size()) begin
            m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            @(posedge clk); #1;
            n++;
            if (n > 5000) begin
                tests++; fails++;
                $display("FAIL drain_timeout: got %0d words, required %0d", got_q.size(), exp_w.size());
                break;
            end
        end
        m_tready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++; if (s_tready_a !== 1'b0) begin fails++; $display("FAIL reset_tready: got %b, required 0", s_tready_a); end
        tests++; if (m_tvalid_a !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b, required 0", m_tvalid_a); end
        tests++; if (m_tlast_a !== 1'b0) begin fails++; $display("FAIL reset_tlast: got %b, required 0", m_tlast_a); end
        tests++; if (m_tdata_a !== 32'h0) begin fails++; $display("FAIL reset_tdata: got %h, required 0", m_tdata_a); end
        tests++; if (pkt_frames_a !== 32'h0) begin fails++; $display("FAIL reset_pkt_frames: got %0d, required 0", pkt_frames_a); end
        tests++; if (pkt_done_a !== 1'b0) begin fails++; $display("FAIL reset_pkt_done: got %b, required 0", pkt_done_a); end
        @(posedge clk); #1;
        areset = 1'b0;
        @(negedge clk);
        tests++; if (s_tready_a !== 1'b1) begin fails++; $display("FAIL post_reset_tready: got %b, required 1", s_tready_a); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_frame;
        int h0;
        clear_logs();
        h0 = hsk_err;
        frm_d.push_back(64'h1111_2222_3333_4444);
        frm_l.push_back(1'b1);
        build_exp(1'b1);
        drive(1'b0);
        tests++; if (got_q.size() != 2) begin fails++; $display("FAIL single_count: got %0d words, required 2", got_q.size()); end
        tests++; if (got_q[0] !== word_t'({32'h1111_2222, 1'b0})) begin fails++; $display("FAIL single_w0: got %h/%b, required 11112222/0", got_q[0].d, got_q[0].l); end
        tests++; if (got_q[1] !== word_t'({32'h3333_4444, 1'b1})) begin fails++; $display("FAIL single_w1: got %h/%b, required 33334444/1", got_q[1].d, got_q[1].l); end
        tests++; if (got_cyc[0] != first_hs_cyc + 1) begin fails++; $display("FAIL single_latency: first word cycle %0d, required %0d", got_cyc[0], first_hs_cyc + 1); end
        tests++; if (got_cyc[1] != got_cyc[0] + 1) begin fails++; $display("FAIL single_consecutive: cycle %0d, required %0d", got_cyc[1], got_cyc[0] + 1); end
        tests++; if (done_q.size() != 1) begin fails++; $display("FAIL single_done_pulses: got %0d, required 1", done_q.size()); end
        tests++; if (done_q[0] !== 32'd1) begin fails++; $display("FAIL single_pkt_frames: got %0d, required 1", done_q[0]); end
        tests++; if (hsk_err != h0) begin fails++; $display("FAIL single_hsked: %0d bad cycles, required 0", hsk_err - h0); end
    endtask

    task automatic test_low_first;
        clear_logs();
        frm_d.push_back(64'hAAAA_BBBB_CCCC_DDDD);
        frm_l.push_back(1'b1);
        build_exp(1'b1);
        drive(1'b0);
        tests++; if (got_b.size() != 2) begin fails++; $display("FAIL low_first_count: got %0d words, required 2", got_b.size()); end
        tests++; if (got_b[0] !== word_t'({32'hCCCC_DDDD, 1'b0})) begin fails++; $display("FAIL low_first_w0: got %h/%b, required ccccdddd/0", got_b[0].d, got_b[0].l); end
        tests++; if (got_b[1] !== word_t'({32'hAAAA_BBBB, 1'b1})) begin fails++; $display("FAIL low_first_w1: got %h/%b, required aaaabbbb/1", got_b[1].d, got_b[1].l); end
    endtask

    task automatic test_back_to_back;
        int nl;
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            frm_d.push_back({$urandom, $urandom});
            frm_l.push_back(i == 7);
        end
        build_exp(1'b1);
        drive(1'b0);
        tests++; if (got_q.size() != 16) begin fails++; $display("FAIL b2b_count: got %0d words, required 16", got_q.size()); end
        nl = 0;
        for (int k = 0; k < got_q.size() && k < 16; k++) begin
            if (got_q[k].l) nl++;
            tests++; if (got_q[k] !== exp_w[k]) begin fails++; $display("FAIL b2b_word%0d: got %h/%b, required %h/%b", k, got_q[k].d, got_q[k].l, exp_w[k].d, exp_w[k].l); end
            tests++; if (got_cyc[k] != got_cyc[0] + k) begin fails++; $display("FAIL b2b_bubble%0d: cycle %0d, required %0d", k, got_cyc[k], got_cyc[0] + k); end
        end
        tests++; if (nl != 1) begin fails++; $display("FAIL b2b_tlast_count: got %0d, required 1", nl); end
        tests++; if (done_q.size() != 1 || done_q[0] !== 32'd8) begin fails++; $display("FAIL b2b_pkt_frames: got %0d reports (first %0d), required one of 8", done_q.size(), done_q[0]); end
    endtask

    task automatic test_random_stall;
        int s0;
        int bad;
        clear_logs();
        s0 = stall_err;
        for (int i = 0; i < 100; i++) begin
            frm_d.push_back({$urandom, $urandom});
            frm_l.push_back(($urandom_range(0, 7) == 0) || (i == 99));
        end
        build_exp(1'b1);
        drive(1'b1);
        tests++; if (got_q.size() != exp_w.size()) begin fails++; $display("FAIL stall_count: got %0d words, required %0d", got_q.size(), exp_w.size()); end
        bad = 0;
        for (int k = 0; k < exp_w.size() && k < got_q.size(); k++) begin
            tests++;
            if (got_q[k] !== exp_w[k]) begin
                fails++; bad++;
                if (bad < 5) $display("FAIL stall_word%0d: got %h/%b, required %h/%b", k, got_q[k].d, got_q[k].l, exp_w[k].d, exp_w[k].l);
            end
        end
        tests++; if (stall_err != s0) begin fails++; $display("FAIL stall_stability: %0d unstable cycles, required 0", stall_err - s0); end
        tests++; if (done_q.size() != exp_done.size()) begin fails++; $display("FAIL stall_done_count: got %0d, required %0d", done_q.size(), exp_done.size()); end
        for (int k = 0; k < exp_done.size() && k < done_q.size(); k++) begin
            tests++; if (done_q[k] !== exp_done[k]) begin fails++; $display("FAIL stall_pkt%0d: got %0d, required %0d", k, done_q[k], exp_done[k]); end
        end
    endtask

    task automatic test_reset_mid_packet;
        int i;
        int n;
        int nl;
        clear_logs();
        i = 0;
        n = 0;
        while (i < 3 && n < 100) begin
            s_tvalid = 1'b1;
            s_tdata  = {$urandom, $urandom};
            s_tlast  = 1'b0;
            m_tready = 1'b1;
            @(negedge clk);
            if (s_tready_a) i++;
            @(posedge clk); #1;
            n++;
        end
        // Now holding frame 3 of 5 in FIRST; reset with frame 4 still offered.
        areset   = 1'b1;
        m_tready = 1'b0;
        @(negedge clk);
        tests++; if (m_tvalid_a !== 1'b1) begin fails++; $display("FAIL mid_first_valid: got %b, required 1", m_tvalid_a); end
        tests++; if (s_tready_a !== 1'b0) begin fails++; $display("FAIL mid_reset_tready: got %b, required 0", s_tready_a); end
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if (m_tvalid_a !== 1'b0) begin fails++; $display("FAIL mid_reset_tvalid: got %b, required 0", m_tvalid_a); end
        tests++; if (pkt_frames_a !== 32'd0) begin fails++; $display("FAIL mid_reset_pkt_frames: got %0d, required 0", pkt_frames_a); end
        @(posedge clk); #1;
        areset   = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        nl = 0;
        foreach (got_q[k]) if (got_q[k].l) nl++;
        tests++; if (got_q.size() != 4 || nl != 0) begin fails++; $display("FAIL mid_aborted_words: got %0d words %0d tlast, required 4 words 0 tlast", got_q.size(), nl); end
        clear_logs();
        for (int k = 0; k < 2; k++) begin
            frm_d.push_back({$urandom, $urandom});
            frm_l.push_back(k == 1);
        end
        build_exp(1'b1);
        drive(1'b0);
        tests++; if (done_q.size() != 1 || done_q[0] !== 32'd2) begin fails++; $display("FAIL mid_after_pkt: got %0d reports (first %0d), required one of 2", done_q.size(), done_q[0]); end
        for (int k = 0; k < exp_w.size() && k < got_q.size(); k++) begin
            tests++; if (got_q[k] !== exp_w[k]) begin fails++; $display("FAIL mid_after_word%0d: got %h/%b, required %h/%b", k, got_q[k].d, got_q[k].l, exp_w[k].d, exp_w[k].l); end
        end
    endtask

    task automatic test_two_packets;
        int nl;
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            frm_d.push_back({$urandom, $urandom});
            frm_l.push_back(i == 2 || i == 3);
        end
        build_exp(1'b1);
        drive(1'b0);
        nl = 0;
        foreach (got_q[k]) if (got_q[k].l) nl++;
        tests++; if (nl != 2) begin fails++; $display("FAIL two_pkt_tlast: got %0d, required 2", nl); end
        tests++; if (done_q.size() != 2) begin fails++; $display("FAIL two_pkt_done_count: got %0d, required 2", done_q.size()); end
        tests++; if (done_q[0] !== 32'd3) begin fails++; $display("FAIL two_pkt_first: got %0d, required 3", done_q[0]); end
        tests++; if (done_q[1] !== 32'd1) begin fails++; $display("FAIL two_pkt_second: got %0d, required 1", done_q[1]); end
        tests++; if (got_q.size() != exp_w.size()) begin fails++; $display("FAIL two_pkt_count: got %0d, required %0d", got_q.size(), exp_w.size()); end
        for (int k = 0; k < exp_w.size() && k < got_q.size(); k++) begin
            tests++; if (got_q[k] !== exp_w[k]) begin fails++; $display("FAIL two_pkt_word%0d: got %h/%b, required %h/%b", k, got_q[k].d, got_q[k].l, exp_w[k].d, exp_w[k].l); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset   = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single_frame();
        test_low_first();
        test_back_to_back();
        test_random_stall();
        test_reset_mid_packet();
        test_two_packets();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
